// File: rtl/painterengine_gpu_dma_pkg.sv
// Shared definitions for the GPU DMA burst controller: FSM state encoding,
// the 4 KiB page constant and the bytes-per-beat helper.
package painterengine_gpu_dma_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } dma_state_t;

   // Bursts must not cross an AXI 4 KiB page
   localparam int unsigned BOUNDARY_4K_BYTES = 4096;

   // Number of bytes moved per data beat for a given bus width in bits
   function automatic int unsigned bytes_per_beat(input int unsigned data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/painterengine_gpu_dma_burst_ctrl_if.sv
// Command / burst-engine / status bundle of the GPU DMA burst controller.
// master: the controller itself; slave: command source plus burst engine.
interface painterengine_gpu_dma_burst_ctrl_if #(
   parameter int PARAM_ADDRESS_WIDTH = 32
) ();

   // command side
   logic                           i_wire_cmd_valid;
   logic                           o_wire_cmd_ready;
   logic                           i_wire_cmd_opcode_0r_1w;
   logic [PARAM_ADDRESS_WIDTH-1:0] i_wire_cmd_address;
   logic [31:0]                    i_wire_cmd_size;

   // burst engine side
   logic                           o_wire_burst_valid;
   logic                           i_wire_burst_ready;
   logic                           o_wire_burst_opcode_0r_1w;
   logic [PARAM_ADDRESS_WIDTH-1:0] o_wire_burst_address;
   logic [7:0]                     o_wire_burst_len;
   logic                           i_wire_burst_done;
   logic                           i_wire_burst_error;

   // status
   logic                           o_wire_done;
   logic                           o_wire_error;
   logic                           o_wire_busy;

   modport master (
      input  i_wire_cmd_valid, i_wire_cmd_opcode_0r_1w, i_wire_cmd_address, i_wire_cmd_size,
      input  i_wire_burst_ready, i_wire_burst_done, i_wire_burst_error,
      output o_wire_cmd_ready, o_wire_burst_valid, o_wire_burst_opcode_0r_1w,
      output o_wire_burst_address, o_wire_burst_len,
      output o_wire_done, o_wire_error, o_wire_busy
   );

   modport slave (
      output i_wire_cmd_valid, i_wire_cmd_opcode_0r_1w, i_wire_cmd_address, i_wire_cmd_size,
      output i_wire_burst_ready, i_wire_burst_done, i_wire_burst_error,
      input  o_wire_cmd_ready, o_wire_burst_valid, o_wire_burst_opcode_0r_1w,
      input  o_wire_burst_address, o_wire_burst_len,
      input  o_wire_done, o_wire_error, o_wire_busy
   );

endinterface

// File: rtl/painterengine_gpu_dma_burst_calc.sv
// Next-burst beat count: min(remaining, max burst length[, beats to 4 KiB page end]).
// Optional feature macro: PAINTERENGINE_GPU_DMA_4K_SPLIT_EN enables the page-boundary term.
module painterengine_gpu_dma_burst_calc
   import painterengine_gpu_dma_pkg::*;
#(
   parameter int PARAM_DATA_WIDTH    = 32,
   parameter int PARAM_MAX_BURST_LEN = 16
) (
   input  logic [31:0] i_remaining,
   input  logic [11:0] i_address_low,
   output logic [8:0]  o_beats
);

   localparam int LOG2_BPB = $clog2(bytes_per_beat(PARAM_DATA_WIDTH));

   logic [8:0] w_rem_cap;

   // Remaining beats clipped to the maximum burst; fits 9 bits once clipped
   assign w_rem_cap = (i_remaining > 32'(PARAM_MAX_BURST_LEN)) ? 9'(PARAM_MAX_BURST_LEN)
                                                               : i_remaining[8:0];

`ifdef PAINTERENGINE_GPU_DMA_4K_SPLIT_EN
   logic [12:0] w_bound_bytes;
   logic [12:0] w_bound_beats;

   // Address is beat aligned here, so the division is exact
   assign w_bound_bytes = 13'(BOUNDARY_4K_BYTES) - {1'b0, i_address_low};
   assign w_bound_beats = w_bound_bytes >> LOG2_BPB;
   assign o_beats = ({4'd0, w_rem_cap} > w_bound_beats) ? w_bound_beats[8:0] : w_rem_cap;
`else
   logic w_unused_address_low;

   assign w_unused_address_low = ^i_address_low;
   assign o_beats = w_rem_cap;
`endif

endmodule

// File: rtl/painterengine_gpu_dma_burst_ctrl.sv
// GPU DMA burst controller: splits a byte-sized read/write command into AXI
// bursts, one outstanding at a time, and reports completion/error.
// Optional feature macro: PAINTERENGINE_GPU_DMA_4K_SPLIT_EN (4 KiB page splitting).
module painterengine_gpu_dma_burst_ctrl
   import painterengine_gpu_dma_pkg::*;
#(
   parameter int PARAM_DATA_WIDTH    = 32,
   parameter int PARAM_ADDRESS_WIDTH = 32,
   parameter int PARAM_MAX_BURST_LEN = 16
) (
   input  logic                                  i_wire_clock,
   input  logic                                  i_wire_reset,
   painterengine_gpu_dma_burst_ctrl_if.master    bus
);

   localparam int LOG2_BPB = $clog2(bytes_per_beat(PARAM_DATA_WIDTH));

   dma_state_t                      r_state;
   logic                            r_cmd_ready;
   logic                            r_opcode;
   logic [PARAM_ADDRESS_WIDTH-1:0]  r_addr;
   logic [31:0]                     r_remaining;
   logic [8:0]                      r_beats;
   logic                            r_burst_valid;
   logic [PARAM_ADDRESS_WIDTH-1:0]  r_burst_addr;
   logic [7:0]                      r_burst_len;
   logic                            r_done;
   logic                            r_error;

   logic                            w_accept;
   logic                            w_misaligned;
   logic [31:0]                     w_cmd_beats;
   logic [31:0]                     w_calc_rem;
   logic [11:0]                     w_calc_addr;
   logic [8:0]                      w_calc_beats;
   logic [7:0]                      w_calc_len;
   logic [PARAM_ADDRESS_WIDTH-1:0]  w_step;

   assign w_accept     = r_cmd_ready & bus.i_wire_cmd_valid;
   assign w_misaligned = (bus.i_wire_cmd_address[LOG2_BPB-1:0] != '0) ||
                         (bus.i_wire_cmd_size[LOG2_BPB-1:0] != '0);
   assign w_cmd_beats  = bus.i_wire_cmd_size >> LOG2_BPB;

   // In IDLE the first burst is sized straight from the incoming command so it
   // can be presented in the cycle after accept; afterwards from the counters.
   assign w_calc_rem  = (r_state == ST_IDLE) ? w_cmd_beats : r_remaining;
   assign w_calc_addr = (r_state == ST_IDLE) ? bus.i_wire_cmd_address[11:0] : r_addr[11:0];
   assign w_calc_len  = 8'(w_calc_beats - 9'd1);
   assign w_step      = PARAM_ADDRESS_WIDTH'({23'd0, r_beats} << LOG2_BPB);

   painterengine_gpu_dma_burst_calc #(
      .PARAM_DATA_WIDTH    (PARAM_DATA_WIDTH),
      .PARAM_MAX_BURST_LEN (PARAM_MAX_BURST_LEN)
   ) u_burst_calc (
      .i_remaining   (w_calc_rem),
      .i_address_low (w_calc_addr),
      .o_beats       (w_calc_beats)
   );

   // Command FSM with all outputs registered
   always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
      if (i_wire_reset) begin
         r_state       <= ST_IDLE;
         r_cmd_ready   <= 1'b0;
         r_opcode      <= 1'b0;
         r_addr        <= '0;
         r_remaining   <= '0;
         r_beats       <= '0;
         r_burst_valid <= 1'b0;
         r_burst_addr  <= '0;
         r_burst_len   <= '0;
         r_done        <= 1'b0;
         r_error       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (w_accept) begin
                  r_cmd_ready <= 1'b0;
                  r_opcode    <= bus.i_wire_cmd_opcode_0r_1w;
                  r_addr      <= bus.i_wire_cmd_address;
                  r_remaining <= w_cmd_beats;
                  r_error     <= w_misaligned;
                  if (w_misaligned || (bus.i_wire_cmd_size == 32'd0)) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state       <= ST_ISSUE;
                     r_burst_valid <= 1'b1;
                     r_burst_addr  <= bus.i_wire_cmd_address;
                     r_burst_len   <= w_calc_len;
                     r_beats       <= w_calc_beats;
                  end
               end else begin
                  r_cmd_ready <= 1'b1;
               end
            end
            ST_ISSUE: begin
               if (bus.i_wire_burst_ready) begin
                  r_burst_valid <= 1'b0;
                  r_addr        <= r_addr + w_step;
                  r_remaining   <= r_remaining - {23'd0, r_beats};
                  r_state       <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (bus.i_wire_burst_done) begin
                  if (bus.i_wire_burst_error) begin
                     r_error <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else if (r_remaining == 32'd0) begin
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_burst_valid <= 1'b1;
                     r_burst_addr  <= r_addr;
                     r_burst_len   <= w_calc_len;
                     r_beats       <= w_calc_beats;
                     r_state       <= ST_ISSUE;
                  end
               end
            end
            ST_DONE: begin
               r_done      <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.o_wire_cmd_ready          = r_cmd_ready;
   assign bus.o_wire_burst_valid        = r_burst_valid;
   assign bus.o_wire_burst_opcode_0r_1w = r_opcode;
   assign bus.o_wire_burst_address      = r_burst_addr;
   assign bus.o_wire_burst_len          = r_burst_len;
   assign bus.o_wire_done               = r_done;
   assign bus.o_wire_error              = r_error;
   assign bus.o_wire_busy               = (r_state != ST_IDLE);

endmodule

// File: tb/tb_painterengine_gpu_dma_burst_ctrl.sv
// Scoreboard bench for the GPU DMA burst controller (32-bit data, 16-beat bursts).
// Stimulus pushes expected bursts/completions; a monitor pops and compares.
module tb_painterengine_gpu_dma_burst_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   painterengine_gpu_dma_burst_ctrl_if #(.PARAM_ADDRESS_WIDTH(32)) bus ();

   painterengine_gpu_dma_burst_ctrl #(
      .PARAM_DATA_WIDTH    (32),
      .PARAM_ADDRESS_WIDTH (32),
      .PARAM_MAX_BURST_LEN (16)
   ) dut (
      .i_wire_clock (clk),
      .i_wire_reset (rst),
      .bus          (bus)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
      logic        op;
   } burst_t;

   burst_t burst_q[$];
   logic   done_q[$];
   int     checks = 0;
   int     errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic pb(input logic [31:0] a, input logic [7:0] l, input logic o);
      burst_q.push_back({a, l, o});
   endtask

   // Monitor: compares every burst handshake and every done pulse with the queues
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst && bus.o_wire_burst_valid && bus.i_wire_burst_ready) begin : mon_burst
            burst_t act;
            burst_t e;
            act = {bus.o_wire_burst_address, bus.o_wire_burst_len, bus.o_wire_burst_opcode_0r_1w};
            if (burst_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_burst actual addr=0x%08h len=%0d required none",
                        act.addr, act.len);
            end else begin
               e = burst_q.pop_front();
               $display("BURST addr=0x%08h len=%0d op=%0d (required addr=0x%08h len=%0d op=%0d)",
                        act.addr, act.len, act.op, e.addr, e.len, e.op);
               check("burst{addr,len,op}", 64'(act), 64'(e));
            end
         end
         if (bus.o_wire_done) begin
            if (done_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               check("done_error", 64'(bus.o_wire_error), 64'(done_q.pop_front()));
            end
         end
      end
   end

   // Issue one command and act as the burst engine until the done pulse
   task automatic run_cmd(input string tag, input logic op, input logic [31:0] addr,
                          input logic [31:0] size, input int n_exp, input int err_burst,
                          input logic exp_err, input int rdy_delay);
      int   w;
      int   phase;
      int   hold;
      int   wcnt;
      int   nb;
      logic got;
      logic chk_lat;
      logic last;
      w = 0; phase = 0; hold = 0; wcnt = 0; nb = 0; got = 1'b0; chk_lat = 1'b0;
      done_q.push_back(exp_err);
      @(negedge clk);
      #1;
      while (!bus.o_wire_cmd_ready && w < 50) begin
         @(negedge clk);
         #1;
         w++;
      end
      if (!bus.o_wire_cmd_ready) begin
         check("cmd_ready_timeout", 64'd0, 64'd1);
         return;
      end
      bus.i_wire_cmd_valid        = 1'b1;
      bus.i_wire_cmd_opcode_0r_1w = op;
      bus.i_wire_cmd_address      = addr;
      bus.i_wire_cmd_size         = size;
      @(negedge clk);
      #1;
      bus.i_wire_cmd_valid = 1'b0;
      check("err_on_accept", 64'(bus.o_wire_error), 64'((n_exp == 0) ? exp_err : 1'b0));
      check("busy_after_accept", 64'(bus.o_wire_busy), 64'd1);
      chk_lat = (n_exp == 0);
      for (int cyc = 0; cyc < 400 && !got; cyc++) begin
         bus.i_wire_burst_ready = 1'b0;
         bus.i_wire_burst_done  = 1'b0;
         bus.i_wire_burst_error = 1'b0;
         if (chk_lat) begin
            check("done_latency", 64'(bus.o_wire_done), 64'd1);
            chk_lat = 1'b0;
         end
         if (bus.o_wire_done) begin
            got = 1'b1;
         end else if (phase == 0) begin
            if (bus.o_wire_burst_valid) begin
               if (hold < rdy_delay) begin
                  hold++;
               end else begin
                  bus.i_wire_burst_ready = 1'b1;
                  hold  = 0;
                  wcnt  = 2;
                  phase = 1;
               end
            end
         end else begin
            if (wcnt > 0) begin
               wcnt--;
            end else begin
               bus.i_wire_burst_done  = 1'b1;
               bus.i_wire_burst_error = (nb == err_burst);
               last = (nb == err_burst) || (nb == n_exp - 1);
               if (last) chk_lat = 1'b1;
               nb++;
               phase = 0;
            end
         end
         if (!got) begin
            @(negedge clk);
            #1;
         end
      end
      if (!got) begin
         check("done_timeout", 64'd0, 64'd1);
      end else begin
         @(negedge clk);
         #1;
         check("done_one_cycle", 64'(bus.o_wire_done), 64'd0);
         check("err_hold", 64'(bus.o_wire_error), 64'(exp_err));
         check("idle_not_busy", 64'(bus.o_wire_busy), 64'd0);
      end
      check("burst_count", 64'(nb), 64'(n_exp));
      check("bursts_left", 64'(burst_q.size()), 64'd0);
      check("done_left", 64'(done_q.size()), 64'd0);
      $display("CMD %s op=%0d addr=0x%08h size=%0d bursts=%0d error=%0d",
               tag, op, addr, size, nb, bus.o_wire_error);
   endtask

   // Global time limit
   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "time limit");
   end

   // Directed stimulus
   initial begin
      bus.i_wire_cmd_valid        = 1'b0;
      bus.i_wire_cmd_opcode_0r_1w = 1'b0;
      bus.i_wire_cmd_address      = '0;
      bus.i_wire_cmd_size         = '0;
      bus.i_wire_burst_ready      = 1'b0;
      bus.i_wire_burst_done       = 1'b0;
      bus.i_wire_burst_error      = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("reset_outputs",
            {18'd0, bus.o_wire_cmd_ready, bus.o_wire_burst_valid, bus.o_wire_burst_opcode_0r_1w,
             bus.o_wire_burst_address, bus.o_wire_burst_len, bus.o_wire_done,
             bus.o_wire_error, bus.o_wire_busy}, 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("ready_after_reset", 64'(bus.o_wire_cmd_ready), 64'd1);

      // single burst
      pb(32'h1000_0000, 8'd15, 1'b0);
      run_cmd("rd_single", 1'b0, 32'h1000_0000, 32'd64, 1, -1, 1'b0, 0);

      // 4 KiB crossing write, ready held off two cycles
`ifdef PAINTERENGINE_GPU_DMA_4K_SPLIT_EN
      pb(32'h0000_0FF0, 8'd3, 1'b1);
      pb(32'h0000_1000, 8'd11, 1'b1);
      run_cmd("wr_4k", 1'b1, 32'h0000_0FF0, 32'd64, 2, -1, 1'b0, 2);
`else
      pb(32'h0000_0FF0, 8'd15, 1'b1);
      run_cmd("wr_4k", 1'b1, 32'h0000_0FF0, 32'd64, 1, -1, 1'b0, 2);
`endif

      // multi-burst with short tail
      pb(32'h0000_0000, 8'd15, 1'b0);
      pb(32'h0000_0040, 8'd15, 1'b0);
      pb(32'h0000_0080, 8'd15, 1'b0);
      pb(32'h0000_00C0, 8'd1, 1'b0);
      run_cmd("rd_200", 1'b0, 32'h0000_0000, 32'd200, 4, -1, 1'b0, 1);

      // error on second burst stops the command
      pb(32'h0000_0000, 8'd15, 1'b0);
      pb(32'h0000_0040, 8'd15, 1'b0);
      run_cmd("rd_err", 1'b0, 32'h0000_0000, 32'd256, 2, 1, 1'b1, 0);

      // next accept clears the error
      pb(32'h0000_2000, 8'd0, 1'b0);
      run_cmd("rd_one_beat", 1'b0, 32'h0000_2000, 32'd4, 1, -1, 1'b0, 0);

      // misaligned address / size, zero size
      run_cmd("misaligned_addr", 1'b0, 32'h0000_0002, 32'd8, 0, -1, 1'b1, 0);
      run_cmd("zero_size", 1'b1, 32'h0000_0100, 32'd0, 0, -1, 1'b0, 0);
      run_cmd("misaligned_size", 1'b1, 32'h0000_0100, 32'd6, 0, -1, 1'b1, 0);

      // small crossing and address wrap
`ifdef PAINTERENGINE_GPU_DMA_4K_SPLIT_EN
      pb(32'h0000_1FF8, 8'd1, 1'b1);
      pb(32'h0000_2000, 8'd1, 1'b1);
      run_cmd("wr_small_4k", 1'b1, 32'h0000_1FF8, 32'd16, 2, -1, 1'b0, 0);
      pb(32'hFFFF_FFF0, 8'd3, 1'b0);
      pb(32'h0000_0000, 8'd15, 1'b0);
      pb(32'h0000_0040, 8'd11, 1'b0);
      run_cmd("rd_wrap", 1'b0, 32'hFFFF_FFF0, 32'd128, 3, -1, 1'b0, 0);
`else
      pb(32'h0000_1FF8, 8'd3, 1'b1);
      run_cmd("wr_small_4k", 1'b1, 32'h0000_1FF8, 32'd16, 1, -1, 1'b0, 0);
      pb(32'hFFFF_FFF0, 8'd15, 1'b0);
      pb(32'h0000_0030, 8'd15, 1'b0);
      run_cmd("rd_wrap", 1'b0, 32'hFFFF_FFF0, 32'd128, 2, -1, 1'b0, 0);
`endif

      // reset while waiting for burst_done
      pb(32'h0000_3000, 8'd15, 1'b1);
      @(negedge clk);
      #1;
      bus.i_wire_cmd_valid        = 1'b1;
      bus.i_wire_cmd_opcode_0r_1w = 1'b1;
      bus.i_wire_cmd_address      = 32'h0000_3000;
      bus.i_wire_cmd_size         = 32'd64;
      @(negedge clk);
      #1;
      bus.i_wire_cmd_valid = 1'b0;
      check("rst_pre_valid", 64'(bus.o_wire_burst_valid), 64'd1);
      bus.i_wire_burst_ready = 1'b1;
      @(negedge clk);
      #1;
      bus.i_wire_burst_ready = 1'b0;
      check("rst_pre_busy", 64'(bus.o_wire_busy), 64'd1);
      rst = 1'b1;
      #1;
      check("rst_outputs",
            {18'd0, bus.o_wire_cmd_ready, bus.o_wire_burst_valid, bus.o_wire_burst_opcode_0r_1w,
             bus.o_wire_burst_address, bus.o_wire_burst_len, bus.o_wire_done,
             bus.o_wire_error, bus.o_wire_busy}, 64'd0);
      repeat (2) @(negedge clk);
      #1;
      check("rst_hold_ready", 64'(bus.o_wire_cmd_ready), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_release_ready", 64'(bus.o_wire_cmd_ready), 64'd1);
      // a stale engine done after reset must be ignored
      @(negedge clk);
      #1;
      bus.i_wire_burst_done = 1'b1;
      @(negedge clk);
      #1;
      bus.i_wire_burst_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("rst_no_done", 64'(bus.o_wire_done), 64'd0);
         @(negedge clk);
         #1;
      end
      check("rst_idle", {62'd0, bus.o_wire_busy, bus.o_wire_cmd_ready}, 64'd1);
      check("rst_bursts_left", 64'(burst_q.size()), 64'd0);
      $display("CMD rst_mid_burst op=1 addr=0x00003000 size=64 bursts=1 error=%0d", bus.o_wire_error);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/painterengine_gpu_dma_burst_ctrl.md
PAINTERENGINE_GPU_DMA_BURST_CTRL -- requirements
Module: painterengine_gpu_dma_burst_ctrl

Interface
REQ-001 SHALL have parameter PARAM_DATA_WIDTH, default 32, AXI data width in bits (power of two, 32..256).
REQ-002 SHALL have parameter PARAM_ADDRESS_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter PARAM_MAX_BURST_LEN, default 16, maximum beats per burst (1..256).
REQ-004 SHALL have one clock and an asynchronous, active-high reset: i_wire_clock  in  1  clock; i_wire_reset  in  1  async active-high reset.
REQ-005 SHALL have ports i_wire_cmd_valid  in  1  command valid; o_wire_cmd_ready  out  1  command accepted.
REQ-006 SHALL have ports i_wire_cmd_opcode_0r_1w  in  1  0 = read, 1 = write; i_wire_cmd_address  in  PARAM_ADDRESS_WIDTH  start byte address; i_wire_cmd_size  in  32  transfer size in bytes.
REQ-007 SHALL have ports o_wire_burst_valid  out  1; i_wire_burst_ready  in  1; o_wire_burst_opcode_0r_1w  out  1; o_wire_burst_address  out  PARAM_ADDRESS_WIDTH; o_wire_burst_len  out  8  AXI LEN (beats-1).
REQ-008 SHALL have ports i_wire_burst_done  in  1  engine finished current burst; i_wire_burst_error  in  1  burst response error, qualified by done.
REQ-009 SHALL have ports o_wire_done  out  1  one-cycle completion pulse; o_wire_error  out  1  command failed; o_wire_busy  out  1  command in progress.

Function
REQ-010 SHALL implement states IDLE, ISSUE, WAIT, DONE; o_wire_busy = (state != IDLE).
REQ-011 SHALL assert o_wire_cmd_ready only in IDLE; on cmd_valid & cmd_ready SHALL latch opcode, address and size, and clear o_wire_error.
REQ-012 SHALL, on accept, go to DONE with error set if address or size is not a multiple of PARAM_DATA_WIDTH/8 bytes; DONE without error if size = 0; otherwise ISSUE.
REQ-013 SHALL compute burst beats = min(remaining beats, PARAM_MAX_BURST_LEN, beats to next 4 KiB boundary), the boundary term being (4096 - address[11:0]) / bytes-per-beat.
REQ-014 SHALL, in ISSUE, hold o_wire_burst_valid high with address, len and opcode stable until i_wire_burst_ready; on handshake advance address and decrement remaining beats by the burst beats, then go to WAIT.
REQ-015 SHALL keep exactly one burst outstanding; a new burst is issued no earlier than the cycle after i_wire_burst_done.
REQ-016 SHALL, in WAIT on i_wire_burst_done, go to DONE if i_wire_burst_error or remaining = 0, else to ISSUE.
REQ-017 SHALL, on burst error, set o_wire_error and issue no further bursts of that command.
REQ-018 SHALL, in DONE, pulse o_wire_done for exactly one cycle then return to IDLE; o_wire_error SHALL be valid with the pulse and hold until the next command is accepted.
REQ-019 SHALL ignore i_wire_burst_done outside WAIT and i_wire_cmd_valid outside IDLE.
REQ-020 SHALL keep address arithmetic modulo 2^PARAM_ADDRESS_WIDTH and the remaining-beat counter 32 bits wide.

Reset
REQ-021 SHALL, on i_wire_reset asserted at any time including mid-burst, enter IDLE immediately with o_wire_cmd_ready=0 during reset, all other outputs 0, and counters cleared.
REQ-022 SHALL raise o_wire_cmd_ready in the first clock edge after reset deasserts; an outstanding engine burst is abandoned without a done pulse.

Configuration
REQ-023 SHALL honour macro PAINTERENGINE_GPU_DMA_4K_SPLIT_EN: defined, REQ-013 boundary term applies; undefined, the term is omitted and bursts split only by PARAM_MAX_BURST_LEN and remaining size.

Structure
REQ-024 SHALL place state encoding, the 4 KiB boundary constant and the bytes-per-beat function in shared package painterengine_gpu_dma_pkg.
REQ-025 SHALL contain one sub-module, painterengine_gpu_dma_burst_calc, computing the next burst beat count combinationally.

Verification (PARAM_DATA_WIDTH=32, PARAM_MAX_BURST_LEN=16)
REQ-026 Read, addr 0x1000_0000, size 64 -> one burst addr 0x1000_0000 len 15; done pulse one cycle after burst_done, error 0.
REQ-027 Write, addr 0x0000_0FF0, size 64, macro defined -> bursts (0x0FF0, len 3), (0x1000, len 11); macro undefined -> one burst (0x0FF0, len 15).
REQ-028 Read, addr 0, size 200 -> bursts len 15, 15, 15, 1 at 0x00, 0x40, 0x80, 0xC0; one done pulse.
REQ-029 Size 256, burst_error on 2nd burst_done -> no 3rd burst; done pulse with error 1; error clears on next accept.
REQ-030 Addr 0x0000_0002, size 8 -> no burst_valid; done and error asserted in the cycle after accept.
REQ-031 Reset asserted during WAIT with burst_ready held low -> all outputs 0 at once; after release cmd_ready=1, no done pulse.
